// File: rtl/malu_pkg.sv
// Shared constants for the matrix-ALU issuer: op-code values, FSM encoding and sizing defaults.
package malu_pkg;

  localparam int MAX_ELEMS_DEFAULT = 25;
  localparam int TIMEOUT_DEFAULT   = 64;

  // Op-codes are forwarded untouched; these names exist for the host and ALU sides.
  localparam logic [7:0] OP_ADD   = 8'h01;
  localparam logic [7:0] OP_SUB   = 8'h02;
  localparam logic [7:0] OP_DOT   = 8'h03;
  localparam logic [7:0] OP_CROSS = 8'h04;
  localparam logic [7:0] OP_MULI  = 8'h05;
  localparam logic [7:0] OP_DET   = 8'h06;
  localparam logic [7:0] OP_TRANS = 8'h07;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR_S1,
    ST_HDR_S2,
    ST_LOAD1,
    ST_LOAD2,
    ST_ISSUE,
    ST_WAIT,
    ST_OUT_HI,
    ST_OUT_LO
  } state_t;

  function automatic logic is_busy_state(input state_t s);
    return (s == ST_ISSUE) || (s == ST_WAIT) || (s == ST_OUT_HI) || (s == ST_OUT_LO);
  endfunction

endpackage

// File: rtl/malu_operand_buf.sv
// Operand store for one matrix: indexed writes, registered indexed read.
module malu_operand_buf
  import malu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = MAX_ELEMS_DEFAULT,
  parameter int AW    = 5
) (
  input  logic             i_clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_reg;

  always_ff @(posedge i_clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // The first element of a one-element matrix is read in the same cycle it is written.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      rd_data_reg <= '0;
    end else if (rd_en) begin
      rd_data_reg <= (we && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/malu_issuer.sv
// Collects a host matrix frame, issues one ALU request per element index and
// streams each Hi/Lo result back to the host.
module malu_issuer
  import malu_pkg::*;
#(
  parameter int bitness   = 8,
  parameter int MAX_ELEMS = MAX_ELEMS_DEFAULT,
  parameter int TIMEOUT   = TIMEOUT_DEFAULT
) (
  input  logic               i_clk,
  input  logic               reset,
  input  logic               i_valid,
  input  logic [bitness-1:0] i_data,
  output logic               o_busy,
  output logic               o_alu_ready,
  output logic [7:0]         o_op_code,
  output logic [bitness-1:0] o_size_1,
  output logic [bitness-1:0] o_size_2,
  output logic [bitness-1:0] o_mat_1,
  output logic [bitness-1:0] o_mat_2,
  input  logic               i_alu_ready,
  input  logic [bitness-1:0] i_result_Hi,
  input  logic [bitness-1:0] i_result_Lo,
  output logic               o_res_valid,
  output logic [bitness-1:0] o_res_data,
  input  logic               i_res_ack,
  output logic               o_error
);

  localparam int AW = (MAX_ELEMS > 1) ? $clog2(MAX_ELEMS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [bitness-1:0] MAX_W        = bitness'(MAX_ELEMS);
  localparam logic [TW-1:0]      TIMEOUT_LAST = TW'(TIMEOUT - 1);

  state_t             state_reg, state_next;
  logic [7:0]         op_reg, op_next;
  logic [bitness-1:0] s1_reg, s1_next;
  logic [bitness-1:0] s2_reg, s2_next;
  logic [bitness-1:0] idx_reg, idx_next;
  logic [bitness-1:0] k_reg, k_next;
  logic [bitness-1:0] hi_reg, hi_next;
  logic [bitness-1:0] lo_reg, lo_next;
  logic [TW-1:0]      timer_reg, timer_next;
  logic               error_reg, error_next;

  logic [1:0]               buf_we;
  logic [1:0][bitness-1:0]  buf_rd;
  logic                     rd_en;
  logic [AW-1:0]            rd_addr;
  logic [bitness-1:0]       idx_plus;
  logic [bitness-1:0]       k_plus;
  logic [bitness-1:0]       n_elems;

  assign idx_plus = idx_reg + 1'b1;
  assign k_plus   = k_reg + 1'b1;
  assign n_elems  = (s1_reg > s2_reg) ? s1_reg : s2_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_buf
      malu_operand_buf #(
        .WIDTH (bitness),
        .DEPTH (MAX_ELEMS),
        .AW    (AW)
      ) u_buf (
        .i_clk   (i_clk),
        .reset   (reset),
        .we      (buf_we[gi]),
        .wr_addr (idx_reg[AW-1:0]),
        .wr_data (i_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (buf_rd[gi])
      );
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      op_reg    <= '0;
      s1_reg    <= '0;
      s2_reg    <= '0;
      idx_reg   <= '0;
      k_reg     <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      timer_reg <= '0;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      s1_reg    <= s1_next;
      s2_reg    <= s2_next;
      idx_reg   <= idx_next;
      k_reg     <= k_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      timer_reg <= timer_next;
      error_reg <= error_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    s1_next    = s1_reg;
    s2_next    = s2_reg;
    idx_next   = idx_reg;
    k_next     = k_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    timer_next = timer_reg;
    error_next = 1'b0;
    buf_we     = '0;
    rd_en      = 1'b0;
    rd_addr    = '0;

    case (state_reg)
      ST_IDLE: begin
        if (i_valid) begin
          op_next    = 8'(i_data);
          state_next = ST_HDR_S1;
        end
      end
      ST_HDR_S1: begin
        if (i_valid) begin
          s1_next = i_data;
          if (i_data > MAX_W) begin
            error_next = 1'b1;
            state_next = ST_IDLE;
          end else begin
            state_next = ST_HDR_S2;
          end
        end
      end
      ST_HDR_S2: begin
        if (i_valid) begin
          s2_next  = i_data;
          idx_next = '0;
          k_next   = '0;
          if (i_data > MAX_W) begin
            error_next = 1'b1;
            state_next = ST_IDLE;
          end else if (s1_reg != '0) begin
            state_next = ST_LOAD1;
          end else if (i_data != '0) begin
            state_next = ST_LOAD2;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      ST_LOAD1: begin
        if (i_valid) begin
          buf_we[0] = 1'b1;
          if (idx_plus == s1_reg) begin
            idx_next = '0;
            if (s2_reg != '0) begin
              state_next = ST_LOAD2;
            end else begin
              rd_en      = 1'b1;
              state_next = ST_ISSUE;
            end
          end else begin
            idx_next = idx_plus;
          end
        end
      end
      ST_LOAD2: begin
        if (i_valid) begin
          buf_we[1] = 1'b1;
          if (idx_plus == s2_reg) begin
            idx_next   = '0;
            rd_en      = 1'b1;
            state_next = ST_ISSUE;
          end else begin
            idx_next = idx_plus;
          end
        end
      end
      ST_ISSUE: begin
        timer_next = '0;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_alu_ready) begin
          hi_next    = i_result_Hi;
          lo_next    = i_result_Lo;
          state_next = ST_OUT_HI;
        end else if (timer_reg == TIMEOUT_LAST) begin
          error_next = 1'b1;
          state_next = ST_IDLE;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      ST_OUT_HI: begin
        if (i_res_ack) begin
          state_next = ST_OUT_LO;
        end
      end
      ST_OUT_LO: begin
        if (i_res_ack) begin
          if (k_plus == n_elems) begin
            k_next     = '0;
            state_next = ST_IDLE;
          end else begin
            k_next     = k_plus;
            rd_en      = 1'b1;
            rd_addr    = k_plus[AW-1:0];
            state_next = ST_ISSUE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign o_busy      = is_busy_state(state_reg);
  assign o_alu_ready = (state_reg == ST_ISSUE);
  assign o_res_valid = (state_reg == ST_OUT_HI) || (state_reg == ST_OUT_LO);
  assign o_op_code   = op_reg;
  assign o_size_1    = s1_reg;
  assign o_size_2    = s2_reg;
  assign o_error     = error_reg;
  // The shorter matrix is zero-padded up to the longer one.
  assign o_mat_1     = (k_reg < s1_reg) ? buf_rd[0] : '0;
  assign o_mat_2     = (k_reg < s2_reg) ? buf_rd[1] : '0;

  always_comb begin
    o_res_data = '0;
    if (state_reg == ST_OUT_HI) begin
      o_res_data = hi_reg;
    end else if (state_reg == ST_OUT_LO) begin
      o_res_data = lo_reg;
    end
  end

endmodule

// File: tb/tb_malu_issuer.sv
// Frame-level checks of malu_issuer: directed table, hand-written corner sequences, random frames.
module tb_malu_issuer;

  localparam int MAXE = 25;
  localparam int TMO  = 64;

  logic       i_clk;
  logic       reset;
  logic       i_valid;
  logic [7:0] i_data;
  logic       o_busy;
  logic       o_alu_ready;
  logic [7:0] o_op_code;
  logic [7:0] o_size_1, o_size_2, o_mat_1, o_mat_2;
  logic       i_alu_ready;
  logic [7:0] i_result_Hi, i_result_Lo;
  logic       o_res_valid;
  logic [7:0] o_res_data;
  logic       i_res_ack;
  logic       o_error;

  malu_issuer #(.bitness(8), .MAX_ELEMS(MAXE), .TIMEOUT(TMO)) dut (
    .i_clk       (i_clk),
    .reset       (reset),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .o_busy      (o_busy),
    .o_alu_ready (o_alu_ready),
    .o_op_code   (o_op_code),
    .o_size_1    (o_size_1),
    .o_size_2    (o_size_2),
    .o_mat_1     (o_mat_1),
    .o_mat_2     (o_mat_2),
    .i_alu_ready (i_alu_ready),
    .i_result_Hi (i_result_Hi),
    .i_result_Lo (i_result_Lo),
    .o_res_valid (o_res_valid),
    .o_res_data  (o_res_data),
    .i_res_ack   (i_res_ack),
    .o_error     (o_error)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0] op, s1, s2, m1, m2;
  } req_t;

  typedef struct {
    logic [7:0]      op, s1, s2;
    logic [2:0][7:0] e1, e2;
    int              alu_lat, ack_lat;
    logic [7:0]      hi, lo;
    int              exp_n;
    logic [2:0][7:0] exp_m1, exp_m2;
    int              exp_err;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int err_seen, err_cycle, first_req_cycle, last_word_cycle, stable_bad, hang, extra;

  req_t       req_q[$];
  logic [7:0] res_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] exp_m1_q[$], exp_m2_q[$], exp_res_q[$];
  logic [7:0] f_op, f_s1, f_s2;
  logic [7:0] f_e1[$], f_e2[$];
  int         model_err;
  vec_t       vt[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
    cyc++;
    if (o_error) begin
      err_seen++;
      err_cycle = cyc;
    end
  endtask

  task automatic build_tx;
    tx_q.delete();
    tx_q.push_back(f_op);
    tx_q.push_back(f_s1);
    if (f_s1 <= 8'(MAXE)) begin
      tx_q.push_back(f_s2);
      if (f_s2 <= 8'(MAXE)) begin
        foreach (f_e1[i]) tx_q.push_back(f_e1[i]);
        foreach (f_e2[i]) tx_q.push_back(f_e2[i]);
      end
    end
  endtask

  task automatic send_words;
    req_q.delete();
    res_q.delete();
    err_seen = 0; err_cycle = -1; first_req_cycle = -1;
    stable_bad = 0; hang = 0; extra = 0;
    foreach (tx_q[i]) begin
      for (int b = 0; b < 100 && o_busy; b++) tick;
      i_valid = 1'b1;
      i_data  = tx_q[i];
      tick;
    end
    last_word_cycle = cyc;
    i_valid = 1'b0;
    i_data  = '0;
  endtask

  // Acts as ALU (response alu_lat cycles after a request, never if negative) and as host sink.
  task automatic service(input int alu_lat, input int ack_lat, input bit fixed,
                         input logic [7:0] fhi, input logic [7:0] flo, input bit junk);
    int         pend   = 0;
    int         ackc   = ack_lat;
    bit         held_v = 1'b0;
    logic [7:0] held   = '0;
    bit         done   = 1'b0;
    for (int b = 0; b < 4000 && !done; b++) begin
      i_alu_ready = 1'b0;
      if (o_alu_ready) begin
        req_q.push_back(req_t'{o_op_code, o_size_1, o_size_2, o_mat_1, o_mat_2});
        if (req_q.size() == 1) first_req_cycle = cyc;
        pend = alu_lat;
      end else if (pend > 0) begin
        if ({o_op_code, o_size_1, o_size_2, o_mat_1, o_mat_2} !==
            {req_q[$].op, req_q[$].s1, req_q[$].s2, req_q[$].m1, req_q[$].m2}) stable_bad++;
        pend--;
        if (pend == 0) begin
          i_alu_ready = 1'b1;
          i_result_Hi = fixed ? fhi : (o_mat_1 ^ o_op_code);
          i_result_Lo = fixed ? flo : 8'(o_mat_1 + o_mat_2);
        end
      end
      if (o_res_valid) begin
        if (held_v && (o_res_data !== held)) stable_bad++;
        held   = o_res_data;
        held_v = 1'b1;
        if (ackc == 0) begin
          i_res_ack = 1'b1;
          res_q.push_back(o_res_data);
          ackc   = ack_lat;
          held_v = 1'b0;
        end else begin
          i_res_ack = 1'b0;
          ackc--;
        end
      end else begin
        i_res_ack = 1'b0;
        held_v    = 1'b0;
      end
      i_valid = (junk && o_busy) ? 1'($urandom_range(0, 1)) : 1'b0;
      i_data  = 8'($urandom);
      if (!o_busy) done = 1'b1;
      else tick;
    end
    hang = done ? 0 : 1;
    i_alu_ready = 1'b0;
    i_res_ack   = 1'b0;
    i_valid     = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick;
      if (o_alu_ready || o_res_valid || o_busy) extra++;
    end
  endtask

  // Reference: zero-pad the shorter matrix, one request per index, Hi/Lo per request.
  task automatic model_expect;
    int n;
    logic [7:0] m1, m2;
    exp_m1_q.delete(); exp_m2_q.delete(); exp_res_q.delete();
    model_err = ((f_s1 > 8'(MAXE)) || (f_s2 > 8'(MAXE))) ? 1 : 0;
    if (model_err == 0) begin
      n = (f_s1 > f_s2) ? int'(f_s1) : int'(f_s2);
      for (int k = 0; k < n; k++) begin
        m1 = (k < int'(f_s1)) ? f_e1[k] : 8'h00;
        m2 = (k < int'(f_s2)) ? f_e2[k] : 8'h00;
        exp_m1_q.push_back(m1);
        exp_m2_q.push_back(m2);
        exp_res_q.push_back(m1 ^ f_op);
        exp_res_q.push_back(8'(m1 + m2));
      end
    end
  endtask

  task automatic check_frame(input string tag, input int exp_err);
    int n = exp_m1_q.size();
    check({tag, ".nreq"}, 64'(req_q.size()), 64'(n));
    for (int k = 0; k < n && k < req_q.size(); k++)
      check({tag, ".req"}, {req_q[k].op, req_q[k].s1, req_q[k].s2, req_q[k].m1, req_q[k].m2},
            {f_op, f_s1, f_s2, exp_m1_q[k], exp_m2_q[k]});
    check({tag, ".nres"}, 64'(res_q.size()), 64'(exp_res_q.size()));
    for (int i = 0; i < exp_res_q.size() && i < res_q.size(); i++)
      check({tag, ".res"}, 64'(res_q[i]), 64'(exp_res_q[i]));
    check({tag, ".errors"}, 64'(err_seen), 64'(exp_err));
    if (exp_err != 0 && n == 0) check({tag, ".err_lat"}, 64'(err_cycle), 64'(last_word_cycle));
    if (n > 0) check({tag, ".req_lat"}, 64'(first_req_cycle), 64'(last_word_cycle));
    check({tag, ".stable"}, 64'(stable_bad), 64'(0));
    check({tag, ".done"}, 64'(hang), 64'(0));
    check({tag, ".extra"}, 64'(extra), 64'(0));
    $display("frame %s op=%02h s1=%0d s2=%0d reqs=%0d results=%0d errors=%0d",
             tag, f_op, f_s1, f_s2, req_q.size(), res_q.size(), err_seen);
  endtask

  task automatic all_outputs_zero(input string name);
    check(name, {o_busy, o_alu_ready, o_res_valid, o_error, o_op_code, o_size_1, o_size_2,
                 o_mat_1, o_mat_2, o_res_data}, 64'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; i_valid = 1'b0; i_data = '0; i_alu_ready = 1'b0;
    i_result_Hi = '0; i_result_Lo = '0; i_res_ack = 1'b0;
    repeat (3) tick;
    all_outputs_zero("reset_state");
    reset = 1'b0;
    tick;

    // op, s1, s2, e1, e2, alu_lat, ack_lat, hi, lo, exp_n, exp_m1, exp_m2, exp_err
    vt.push_back('{8'h01, 8'd2, 8'd2, {8'h00, 8'h04, 8'h03}, {8'h00, 8'h06, 8'h05}, 2, 0,
                   8'h00, 8'h08, 2, {8'h00, 8'h04, 8'h03}, {8'h00, 8'h06, 8'h05}, 0});
    vt.push_back('{8'h03, 8'd3, 8'd1, {8'h0C, 8'h0B, 8'h0A}, {8'h00, 8'h00, 8'h0D}, 1, 0,
                   8'h5A, 8'hA5, 3, {8'h0C, 8'h0B, 8'h0A}, {8'h00, 8'h00, 8'h0D}, 0});
    vt.push_back('{8'h04, 8'd26, 8'd0, '0, '0, 1, 0, 8'h00, 8'h00, 0, '0, '0, 1});
    vt.push_back('{8'h01, 8'd2, 8'd2, {8'h00, 8'h22, 8'h11}, {8'h00, 8'h44, 8'h33}, 3, 1,
                   8'h12, 8'h34, 2, {8'h00, 8'h22, 8'h11}, {8'h00, 8'h44, 8'h33}, 0});
    vt.push_back('{8'h02, 8'd1, 8'd26, '0, '0, 1, 0, 8'h00, 8'h00, 0, '0, '0, 1});
    vt.push_back('{8'h07, 8'd0, 8'd0, '0, '0, 1, 0, 8'h00, 8'h00, 0, '0, '0, 0});
    vt.push_back('{8'h05, 8'd0, 8'd2, '0, {8'h00, 8'h08, 8'h07}, 1, 0,
                   8'h01, 8'h02, 2, '0, {8'h00, 8'h08, 8'h07}, 0});
    vt.push_back('{8'h06, 8'd1, 8'd0, {8'h00, 8'h00, 8'h99}, '0, 2, 2,
                   8'hE1, 8'h1E, 1, {8'h00, 8'h00, 8'h99}, '0, 0});
    vt.push_back('{8'h02, 8'd1, 8'd1, {8'h00, 8'h00, 8'h21}, {8'h00, 8'h00, 8'h42}, 1, 10,
                   8'hAB, 8'hCD, 1, {8'h00, 8'h00, 8'h21}, {8'h00, 8'h00, 8'h42}, 0});
    vt.push_back('{8'h03, 8'd2, 8'd1, {8'h00, 8'h02, 8'h01}, {8'h00, 8'h00, 8'h03}, TMO, 0,
                   8'h0F, 8'hF0, 2, {8'h00, 8'h02, 8'h01}, {8'h00, 8'h00, 8'h03}, 0});

    foreach (vt[v]) begin
      f_op = vt[v].op; f_s1 = vt[v].s1; f_s2 = vt[v].s2;
      f_e1.delete(); f_e2.delete();
      for (int j = 0; j < 3; j++) begin
        if (j < int'(f_s1)) f_e1.push_back(vt[v].e1[j]);
        if (j < int'(f_s2)) f_e2.push_back(vt[v].e2[j]);
      end
      exp_m1_q.delete(); exp_m2_q.delete(); exp_res_q.delete();
      for (int k = 0; k < vt[v].exp_n; k++) begin
        exp_m1_q.push_back(vt[v].exp_m1[k]);
        exp_m2_q.push_back(vt[v].exp_m2[k]);
        exp_res_q.push_back(vt[v].hi);
        exp_res_q.push_back(vt[v].lo);
      end
      build_tx();
      send_words();
      service(vt[v].alu_lat, vt[v].ack_lat, 1'b1, vt[v].hi, vt[v].lo, 1'b0);
      check_frame($sformatf("vec%0d", v), vt[v].exp_err);
    end

    // ALU never answers: error TMO+1 samples after the request appears, frame abandoned.
    f_op = 8'h05; f_s1 = 8'd1; f_s2 = 8'd1;
    f_e1 = '{8'h10}; f_e2 = '{8'h20};
    build_tx();
    send_words();
    service(-1, 0, 1'b0, 8'h00, 8'h00, 1'b0);
    exp_m1_q = '{8'h10}; exp_m2_q = '{8'h20}; exp_res_q.delete();
    check_frame("timeout", 1);
    check("timeout.err_cycle", 64'(err_cycle), 64'(first_req_cycle + TMO + 1));
    check("timeout.busy", 64'(o_busy), 64'd0);

    // Reset while a result is being offered and not acknowledged.
    f_op = 8'h02; f_s1 = 8'd1; f_s2 = 8'd1;
    f_e1 = '{8'h31}; f_e2 = '{8'h32};
    build_tx();
    send_words();
    check("rst_seq.issue", {o_alu_ready, o_mat_1, o_mat_2}, {1'b1, 8'h31, 8'h32});
    tick;
    i_alu_ready = 1'b1; i_result_Hi = 8'h77; i_result_Lo = 8'h66;
    tick;
    i_alu_ready = 1'b0;
    check("rst_seq.out_hi", {o_res_valid, o_res_data}, {1'b1, 8'h77});
    reset = 1'b1;
    tick;
    all_outputs_zero("rst_seq.in_reset");
    reset = 1'b0;
    tick;
    all_outputs_zero("rst_seq.after");
    $display("frame rst_seq op=02 s1=1 s2=1 reset during result offer");

    // Random frames against the reference model, junk words offered while busy.
    for (int f = 0; f < 30; f++) begin
      f_op = 8'($urandom);
      f_s1 = (f == 0) ? 8'(MAXE) : 8'($urandom_range(0, MAXE));
      f_s2 = (f == 0) ? 8'(MAXE) : 8'($urandom_range(0, MAXE));
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) f_s1 = 8'($urandom_range(MAXE + 1, 255));
        else f_s2 = 8'($urandom_range(MAXE + 1, 255));
      end
      f_e1.delete(); f_e2.delete();
      if (f_s1 <= 8'(MAXE)) for (int j = 0; j < int'(f_s1); j++) f_e1.push_back(8'($urandom));
      if (f_s2 <= 8'(MAXE)) for (int j = 0; j < int'(f_s2); j++) f_e2.push_back(8'($urandom));
      model_expect();
      build_tx();
      send_words();
      service($urandom_range(1, 6), $urandom_range(0, 3), 1'b0, 8'h00, 8'h00, 1'b1);
      check_frame($sformatf("rand%0d", f), model_err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
